seg_display_scan: RTL and testbench
===================================

# seg_display_scan

Downstream display stage for the alarm clock. Consumes the 14-bit packed HH:MM count, decimal-point enable and edit-field LED flags produced by the time/alarm counter block. Time-multiplexes the four digits onto the board's common-anode 7-segment display, with tear-free frame snapshots, anti-ghosting guard time and blinking of the field being edited.

## Interface
- CLK_HZ, 100_000_000, input clock frequency
- REFRESH_HZ, 250, full 4-digit frame rate; slot length SLOT = CLK_HZ/(4*REFRESH_HZ) cycles, must be ≥ GUARD+2
- BLINK_HZ, 2, edit-blink rate; half-period HALF = CLK_HZ/(2*BLINK_HZ) cycles
- GUARD, 4, cycles per slot with all anodes off
- LZ_BLANK, 0, 1 = blank hour-tens digit when it is 0
- clk  in  1  system clock, single domain
- rst  in  1  asynchronous, active-low reset (0 = reset)
- count  in  14  [3:0] min units, [6:4] min tens, [10:7] hour units, [13:11] hour tens, all BCD
- dp_en  in  1  light the decimal point of digit 2 (HH.MM separator)
- edit  in  4  {LD12,LD13,LD14,LD15}: time-hour, time-min, alarm-hour, alarm-min edit flags
- an  out  4  digit anodes, active-low, an[0] = min units … an[3] = hour tens
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

## Operation
- Reset: an=4'b1111, seg=7'b1111111, dp=1; slot_cnt=0, digit=0, blink phase=visible, snapshot=0.
- slot_cnt runs 0..SLOT-1. At SLOT-1 it returns to 0 and digit advances 0→1→2→3→0.
- Snapshot: on the cycle digit wraps 3→0, and on the first cycle after reset, capture count, dp_en and edit. Inputs are never read mid-frame.
- Digit value: d0=snap[3:0], d1={1'b0,snap[6:4]}, d2=snap[10:7], d3={1'b0,snap[13:11]}.
- Decode: 0-9 standard patterns. Values >9 show a dash (only g lit, seg=7'b0111111).
- Blink: a free-running HALF counter toggles the phase. In the blank phase, digits 2/3 are blanked if edit[3]|edit[1] (hours). Digits 0/1 are blanked if edit[2]|edit[0] (minutes). Blanked means seg=all-ones, dp=1, and the anode is still driven.
- LZ_BLANK=1 and d3==0: digit 3 seg all-ones. Not applied while the hour field is in its blink-visible phase.
- dp=0 only when digit==2 and the snapshot dp_en==1 and the digit is not blanked.
- Guard: slot_cnt < GUARD forces an=4'b1111. seg/dp already show the new digit.
- Multiple edit bits set: OR-combine the rules above; no priority.

## Timing
- All outputs registered. They reflect the internal digit/slot_cnt of the previous cycle (1-cycle latency).
- Each anode is low for SLOT-GUARD consecutive cycles per frame. Exactly one anode is low at any time, or none.
- A count change reaches the display from the next frame start + 1 cycle, so worst case is 4*SLOT+1 cycles.
- Reset asserted mid-frame: outputs go to reset values asynchronously. After release, scanning restarts at digit 0, slot_cnt 0, with a fresh snapshot.
- Blink phase is independent of the frame and is not resynchronised on edit changes.

## Structure
- Package seg_pkg: SEG_BLANK, SEG_DASH, 10-entry digit pattern constants, digit-index constants.
- Sub-module bcd_to_seg (4-bit in, 7-bit active-low out, dash for >9) is the natural split. It is combinational and instantiated once.
- Top holds the slot counter, digit counter, blink counter, snapshot and output registers.

## Test plan
Bench parameters: CLK_HZ=40, REFRESH_HZ=1, BLINK_HZ=1, GUARD=2, giving SLOT=10 and HALF=20.
- Reset held low, then released → an=1111, seg=1111111, dp=1 during reset. First anode an=1110 appears at cycle 3 after release; an[0] stays low for 8 cycles.
- count=14'b010_0011_101_1001 (23:59), dp_en=1, edit=0 → per frame: digit0 seg=0010000 ("9"), digit1 "5", digit2 "3" with dp=0, digit3 "2". A 2-cycle all-off gap precedes each digit.
- count changed to 12:34 at cycle 15 of a frame → the current frame still shows 23:59. The next frame shows 12:34 starting 1 cycle after the wrap.
- edit=4'b1000 → digits 2/3 show 20 cycles and blank 20 cycles alternately. Digits 0/1 are never blank.
- count[3:0]=4'hC → digit0 seg=0111111 (dash). LZ_BLANK=1 with hours 05 → digit3 blank, digit2 "5".
- Reset pulsed low at cycle 25 → outputs go to reset values immediately. After release, scanning restarts at digit 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the alarm-clock display scanner: active-low segment
// patterns {g,f,e,d,c,b,a}, digit positions and the per-frame snapshot record.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic [1:0] {
    DIG_MIN_U  = 2'd0,
    DIG_MIN_T  = 2'd1,
    DIG_HOUR_U = 2'd2,
    DIG_HOUR_T = 2'd3
  } digit_e;

  typedef struct packed {
    logic [13:0] count;
    logic        dp_en;
    logic [3:0]  edit;
  } snap_t;

  function automatic logic [3:0] digit_value(input logic [13:0] cnt, input digit_e idx);
    case (idx)
      DIG_MIN_U:  digit_value = cnt[3:0];
      DIG_MIN_T:  digit_value = {1'b0, cnt[6:4]};
      DIG_HOUR_U: digit_value = cnt[10:7];
      default:    digit_value = {1'b0, cnt[13:11]};
    endcase
  endfunction

endpackage

// File: rtl/seg_display_scan_if.sv
// Link between the time/alarm counter block (master) and the display
// scanner (slave): packed HH:MM, separator and edit flags in, drive pins out.
interface seg_display_scan_if;
  logic [13:0] count;
  logic        dp_en;
  logic [3:0]  edit;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output count, dp_en, edit, input  an, seg, dp);
  modport slave  (input  count, dp_en, edit, output an, seg, dp);
endinterface

// File: rtl/seg_display_scan_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_DIGITS[0];
      4'd1:    o_seg = SEG_DIGITS[1];
      4'd2:    o_seg = SEG_DIGITS[2];
      4'd3:    o_seg = SEG_DIGITS[3];
      4'd4:    o_seg = SEG_DIGITS[4];
      4'd5:    o_seg = SEG_DIGITS[5];
      4'd6:    o_seg = SEG_DIGITS[6];
      4'd7:    o_seg = SEG_DIGITS[7];
      4'd8:    o_seg = SEG_DIGITS[8];
      4'd9:    o_seg = SEG_DIGITS[9];
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_scan.sv
// Four-digit common-anode scanner: frame-wide input snapshot, guard time with
// all anodes off at the start of each slot, and blinking of the edited field.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 250,
  parameter int BLINK_HZ   = 2,
  parameter int GUARD      = 4,
  parameter int LZ_BLANK   = 0
)(
  input  logic clk,
  input  logic rst,
  seg_display_scan_if.slave bus
);

  localparam int SLOT = CLK_HZ / (4 * REFRESH_HZ);
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int SW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT - 1);
  localparam logic [SW-1:0] GUARD_END = SW'(GUARD);
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);

  logic [SW-1:0] r_slot;
  digit_e        r_digit;
  logic [BW-1:0] r_blinkCnt;
  logic          r_blankPhase;
  logic          r_first;
  snap_t         r_snap;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic       w_slotLast;
  logic       w_frameEnd;
  logic [3:0] w_digitVal;
  logic [6:0] w_segDec;
  logic       w_hourEdit;
  logic       w_minEdit;
  logic       w_blinkBlank;
  logic       w_lzBlank;
  logic [3:0] w_anNext;
  logic [6:0] w_segNext;
  logic       w_dpNext;

  assign w_slotLast = (r_slot == SLOT_LAST);
  assign w_frameEnd = w_slotLast && (r_digit == DIG_HOUR_T);
  assign w_digitVal = digit_value(r_snap.count, r_digit);

  bcd_to_seg u_dec (
    .i_bcd (w_digitVal),
    .o_seg (w_segDec)
  );

  // Blanking rules combine by OR; leading-zero suppression yields to a visible edited hour.
  always_comb begin
    w_hourEdit   = r_snap.edit[3] | r_snap.edit[1];
    w_minEdit    = r_snap.edit[2] | r_snap.edit[0];
    w_blinkBlank = r_blankPhase &&
                   ((r_digit == DIG_HOUR_U || r_digit == DIG_HOUR_T) ? w_hourEdit : w_minEdit);
    w_lzBlank    = (LZ_BLANK != 0) && (r_digit == DIG_HOUR_T) && (w_digitVal == 4'd0) &&
                   !(w_hourEdit && !r_blankPhase);
    w_segNext    = (w_blinkBlank || w_lzBlank) ? SEG_BLANK : w_segDec;
    w_dpNext     = ~((r_digit == DIG_HOUR_U) && r_snap.dp_en && !w_blinkBlank);
    w_anNext     = (r_slot < GUARD_END) ? 4'b1111 : ~(4'b0001 << r_digit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot       <= '0;
      r_digit      <= DIG_MIN_U;
      r_blinkCnt   <= '0;
      r_blankPhase <= 1'b0;
      r_first      <= 1'b1;
      r_snap       <= '0;
    end else begin
      r_first <= 1'b0;
      if (w_slotLast) begin
        r_slot  <= '0;
        r_digit <= digit_e'(r_digit + 2'd1);
      end else begin
        r_slot <= r_slot + 1'b1;
      end
      if (r_blinkCnt == HALF_LAST) begin
        r_blinkCnt   <= '0;
        r_blankPhase <= ~r_blankPhase;
      end else begin
        r_blinkCnt <= r_blinkCnt + 1'b1;
      end
      // Inputs are only sampled at frame boundaries so a frame never tears.
      if (r_first || w_frameEnd) begin
        r_snap.count <= bus.count;
        r_snap.dp_en <= bus.dp_en;
        r_snap.edit  <= bus.edit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_anNext;
      r_seg <= w_segNext;
      r_dp  <= w_dpNext;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule

// File: tb/tb_seg_display_scan.sv
// Randomised scoreboard bench for seg_display_scan; two instances cover
// leading-zero blanking off and on with identical stimulus.
module tb_seg_display_scan;

  localparam int CLK_HZ     = 40;
  localparam int REFRESH_HZ = 1;
  localparam int BLINK_HZ   = 1;
  localparam int GUARD      = 2;
  localparam int SLOT       = 10;
  localparam int HALF       = 20;
  localparam int FRAME      = 4 * SLOT;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  typedef struct {
    int    k;
    disp_t lz0;
    disp_t lz1;
  } exp_t;

  localparam disp_t RESET_VAL = {4'b1111, 7'b1111111, 1'b1};
  localparam logic [13:0] T2359 = {3'd2, 4'd3, 3'd5, 4'd9};
  localparam logic [13:0] T1234 = {3'd1, 4'd2, 3'd3, 4'd4};
  localparam logic [13:0] T054C = {3'd0, 4'd5, 3'd4, 4'hC};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] tCount = '0;
  logic        tDpEn  = 1'b0;
  logic [3:0]  tEdit  = '0;

  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [13:0] mCount = '0;
  logic        mDpEn  = 1'b0;
  logic [3:0]  mEdit  = '0;
  exp_t q[$];

  seg_display_scan_if bus0 ();
  seg_display_scan_if bus1 ();

  assign bus0.count = tCount;
  assign bus0.dp_en = tDpEn;
  assign bus0.edit  = tEdit;
  assign bus1.count = tCount;
  assign bus1.dp_en = tDpEn;
  assign bus1.edit  = tEdit;

  seg_display_scan #(
    .CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ), .BLINK_HZ(BLINK_HZ),
    .GUARD(GUARD), .LZ_BLANK(0)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  seg_display_scan #(
    .CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ), .BLINK_HZ(BLINK_HZ),
    .GUARD(GUARD), .LZ_BLANK(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  function automatic logic [6:0] digitPattern(input int v);
    case (v)
      0: digitPattern = 7'b1000000;
      1: digitPattern = 7'b1111001;
      2: digitPattern = 7'b0100100;
      3: digitPattern = 7'b0110000;
      4: digitPattern = 7'b0011001;
      5: digitPattern = 7'b0010010;
      6: digitPattern = 7'b0000010;
      7: digitPattern = 7'b1111000;
      8: digitPattern = 7'b0000000;
      9: digitPattern = 7'b0010000;
      default: digitPattern = 7'b0111111;
    endcase
  endfunction

  // Expected pins after the edge that leaves the n-th scan cycle since reset release.
  function automatic disp_t modelOut(input int n, input logic [13:0] c, input logic dpe,
                                     input logic [3:0] ed, input bit lz);
    int slot, dig, val;
    bit blankPh, hourEd, minEd, blanked, lzb;
    disp_t d;
    slot    = n % SLOT;
    dig     = (n / SLOT) % 4;
    blankPh = ((n / HALF) % 2) == 1;
    case (dig)
      0:       val = int'(c[3:0]);
      1:       val = int'(c[6:4]);
      2:       val = int'(c[10:7]);
      default: val = int'(c[13:11]);
    endcase
    hourEd  = ed[3] | ed[1];
    minEd   = ed[2] | ed[0];
    blanked = blankPh && ((dig >= 2) ? hourEd : minEd);
    lzb     = lz && (dig == 3) && (val == 0) && !(hourEd && !blankPh);
    d.an    = (slot < GUARD) ? 4'b1111 : 4'(~(4'b0001 << dig));
    d.seg   = (blanked || lzb) ? 7'b1111111 : digitPattern(val);
    d.dp    = (dig == 2 && dpe && !blanked) ? 1'b0 : 1'b1;
    return d;
  endfunction

  task automatic checkOutput(input string name, input int kk, input disp_t got, input disp_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s k=%0d got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
               name, kk, got.an, got.seg, got.dp, exp.an, exp.seg, exp.dp);
    end
  endtask

  // Drives inputs from the current negedge and queues the expected pins for each coming edge.
  task automatic applyStimulus(input logic [13:0] c, input logic dpe, input logic [3:0] ed,
                               input int cycles);
    exp_t e;
    tCount = c;
    tDpEn  = dpe;
    tEdit  = ed;
    for (int i = 0; i < cycles; i++) begin
      k++;
      e.k   = k;
      e.lz0 = modelOut(k - 1, mCount, mDpEn, mEdit, 1'b0);
      e.lz1 = modelOut(k - 1, mCount, mDpEn, mEdit, 1'b1);
      q.push_back(e);
      if (k == 1 || (k % FRAME) == 0) begin
        mCount = tCount;
        mDpEn  = tDpEn;
        mEdit  = tEdit;
      end
      @(negedge clk);
    end
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_lz0"}, k, {bus0.an, bus0.seg, bus0.dp}, RESET_VAL);
    checkOutput({name, "_lz1"}, k, {bus1.an, bus1.seg, bus1.dp}, RESET_VAL);
  endtask

  task automatic restartModel();
    k      = 0;
    mCount = '0;
    mDpEn  = 1'b0;
    mEdit  = '0;
  endtask

  // Monitor: one queued expectation per edge, compared just after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checkOutput("scan_lz0", e.k, {bus0.an, bus0.seg, bus0.dp}, e.lz0);
        checkOutput("scan_lz1", e.k, {bus1.an, bus1.seg, bus1.dp}, e.lz1);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog time limit expired at k=%0d", k);
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    int cyc;
    #1 rst = 1'b0;
    tCount = T2359;
    tDpEn  = 1'b1;
    tEdit  = 4'b0000;
    @(negedge clk);
    checkReset("reset_hold_a");
    repeat (2) @(negedge clk);
    checkReset("reset_hold_b");
    $display("[TB] releasing reset");
    rst = 1'b1;
    restartModel();

    applyStimulus(T2359, 1'b1, 4'b0000, FRAME * 2 + 15);
    applyStimulus(T1234, 1'b1, 4'b0000, FRAME + 25);
    applyStimulus(T1234, 1'b0, 4'b1000, FRAME * 2);
    applyStimulus(T054C, 1'b1, 4'b0000, FRAME * 2);
    applyStimulus(T054C, 1'b0, 4'b0010, FRAME);
    applyStimulus(T2359, 1'b1, 4'b0101, FRAME);

    for (int r = 0; r < 10; r++) begin
      applyStimulus(14'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), int'($urandom_range(3, 45)));
    end

    cyc = (25 - (k % FRAME) + FRAME) % FRAME;
    if (cyc == 0) cyc = FRAME;
    applyStimulus(T2359, 1'b1, 4'b0000, cyc);
    #2 rst = 1'b0;
    #1 checkReset("reset_midframe");
    @(negedge clk);
    checkReset("reset_midframe_hold");
    rst = 1'b1;
    restartModel();
    applyStimulus(T1234, 1'b1, 4'b0100, FRAME + 20);

    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
